fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Issues in-order fetch requests to instruction memory under a two-entry
// credit limit. Returned instructions are buffered with their PCs in a
// two-entry FIFO that feeds the decode pipeline register. A redirect
// flushes buffered work and arranges for any still-outstanding responses
// to be dropped as they return.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (current fetch PC)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid, returned in request order
//   imem_rdata   instruction data
//   stall        downstream cannot accept this cycle
//   redirect     branch/flush request from a later stage
//   redirect_pc  new fetch PC
//   o_valid      output entry valid
//   o_pc         PC of the output instruction
//   o_instr      output instruction
module fetch_stage #(
    parameter int unsigned      PC_W     = 8,
    parameter int unsigned      INSTR_W  = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic [PC_W-1:0]    r_fetch_pc;

    // output FIFO of {pc, instr}
    logic [PC_W-1:0]    r_fifo_pc    [2];
    logic [INSTR_W-1:0] r_fifo_instr [2];
    logic               r_fifo_rd;
    logic               r_fifo_wr;
    logic [1:0]         r_fifo_cnt;

    // PCs of requests granted but not yet answered (excluding discarded ones)
    logic [PC_W-1:0]    r_ifq_pc [2];
    logic               r_ifq_rd;
    logic               r_ifq_wr;

    logic [1:0]         r_outstanding;
    logic [1:0]         r_discard;

    logic [2:0]         w_credit_used;
    logic               w_gnt;
    logic               w_rsp;
    logic               w_keep;
    logic               w_pop;
    logic [1:0]         w_out_after_rsp;

    // Outstanding requests plus buffered entries may never exceed the FIFO
    // depth, so every response always has a slot waiting for it.
    assign w_credit_used   = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
    assign imem_req        = !rst && !redirect && (w_credit_used < 3'd2);
    assign imem_addr       = r_fetch_pc;

    assign w_gnt           = imem_req && imem_gnt;
    assign w_rsp           = imem_rvalid && (r_outstanding != 2'd0);
    assign w_keep          = w_rsp && (r_discard == 2'd0);
    assign w_pop           = (r_fifo_cnt != 2'd0) && !stall;
    assign w_out_after_rsp = r_outstanding - 2'(w_rsp);

    assign o_valid = !rst && (r_fifo_cnt != 2'd0);
    assign o_pc    = r_fifo_pc[r_fifo_rd];
    assign o_instr = r_fifo_instr[r_fifo_rd];

    // control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_fifo_rd     <= 1'b0;
            r_fifo_wr     <= 1'b0;
            r_fifo_cnt    <= '0;
            r_ifq_rd      <= 1'b0;
            r_ifq_wr      <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle's response is
            // stale and must be dropped when it returns.
            r_fetch_pc    <= redirect_pc;
            r_fifo_rd     <= 1'b0;
            r_fifo_wr     <= 1'b0;
            r_fifo_cnt    <= '0;
            r_ifq_rd      <= 1'b0;
            r_ifq_wr      <= 1'b0;
            r_outstanding <= w_out_after_rsp;
            r_discard     <= w_out_after_rsp;
        end else begin
            if (w_gnt) begin
                r_ifq_wr   <= ~r_ifq_wr;
                r_fetch_pc <= r_fetch_pc + PC_W'(1);
            end
            if (w_keep) begin
                r_ifq_rd  <= ~r_ifq_rd;
                r_fifo_wr <= ~r_fifo_wr;
            end
            if (w_rsp && !w_keep) begin
                r_discard <= r_discard - 2'd1;
            end
            if (w_pop) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            r_outstanding <= r_outstanding + 2'(w_gnt) - 2'(w_rsp);
            r_fifo_cnt    <= r_fifo_cnt + 2'(w_keep) - 2'(w_pop);
        end
    end

    // storage (no reset needed; validity is tracked by the counters above)
    always_ff @(posedge clk) begin
        if (!rst && !redirect) begin
            if (w_gnt) begin
                r_ifq_pc[r_ifq_wr] <= r_fetch_pc;
            end
            if (w_keep) begin
                r_fifo_pc[r_fifo_wr]    <= r_ifq_pc[r_ifq_rd];
                r_fifo_instr[r_fifo_wr] <= imem_rdata;
            end
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) !(imem_rvalid && (r_outstanding == 2'd0))
    );

endmodule
